frame_pool_28: RTL and testbench

//   Reads the binary 320x240 framebuffer filled by the camera capture stage and

---
 rtl/frame_pool_28_if.sv | 23 ++
 rtl/frame_pool_28.sv | 167 ++++++++++++++++
 tb/tb_frame_pool_28.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_pool_28_if.sv
// Bundle between the pooling engine, the framebuffer read port and the NN input buffer.
// master = pooling engine, slave = framebuffer/consumer side.
interface frame_pool_28_if;
  logic        start;
  logic [16:0] rd_addr;
  logic [11:0] rd_data;
  logic        out_pix;
  logic [9:0]  out_idx;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        frame_done;

  modport master (
    input  start, rd_data, out_ready,
    output rd_addr, out_pix, out_idx, out_valid, busy, frame_done
  );

  modport slave (
    output start, rd_data, out_ready,
    input  rd_addr, out_pix, out_idx, out_valid, busy, frame_done
  );
endinterface

// File: rtl/frame_pool_28.sv
// Pools a centred GRID*BLK square window of the binary framebuffer into a GRIDxGRID
// thresholded image, one BLKxBLK block at a time, streamed out in raster order.
module frame_pool_28 #(
  parameter int unsigned IMG_W  = 320,
  parameter int unsigned X0     = 48,
  parameter int unsigned Y0     = 8,
  parameter int unsigned BLK    = 8,
  parameter int unsigned GRID   = 28,
  parameter int unsigned THRESH = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  frame_pool_28_if.master  bus
);

  localparam int unsigned ADDR_W   = 17;
  localparam int unsigned IDX_W    = 10;
  localparam int unsigned RC_W     = $clog2(BLK);
  localparam int unsigned BX_W     = $clog2(GRID);
  localparam int unsigned CNT_W    = $clog2(BLK * BLK + 1);
  localparam int unsigned DR_W     = $clog2(RD_LAT + 1);
  localparam int unsigned BASE0    = Y0 * IMG_W + X0;
  localparam int unsigned ROW_STEP = BLK * IMG_W - (GRID - 1) * BLK;
  localparam int unsigned LAST_IDX = GRID * GRID - 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_EMIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state, state_nxt;
  logic [RC_W-1:0]   rc_r, rc_c;
  logic [BX_W-1:0]   bx;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [ADDR_W-1:0] blk_base, line_base, rd_addr, next_base;
  logic [DR_W-1:0]   drain_cnt;
  logic [RD_LAT-1:0] vld_pipe;
  logic              out_pix, out_valid, busy, frame_done;
  logic [IDX_W-1:0]  out_idx;
  logic              start_go, drain_end, accept, read_last, last_blk, ret_bit;
  logic              unused_rd_bits;

  assign ret_bit   = vld_pipe[RD_LAT-1] & bus.rd_data[0];
  assign cnt_nxt   = cnt + CNT_W'(ret_bit);
  assign last_blk  = (idx == IDX_W'(LAST_IDX));
  assign read_last = (rc_r == RC_W'(BLK - 1)) && (rc_c == RC_W'(BLK - 1));
  assign next_base = (bx == BX_W'(GRID - 1)) ? blk_base + ADDR_W'(ROW_STEP)
                                              : blk_base + ADDR_W'(BLK);
  assign unused_rd_bits = ^bus.rd_data[11:1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_go  = 1'b0;
    drain_end = 1'b0;
    accept    = 1'b0;
    case (state)
      S_IDLE:  if (bus.start) begin
                 start_go  = 1'b1;
                 state_nxt = S_READ;
               end
      S_READ:  if (read_last) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_cnt == DR_W'(RD_LAT - 1)) begin
                 drain_end = 1'b1;
                 state_nxt = S_EMIT;
               end
      S_EMIT:  if (bus.out_ready) begin
                 accept    = 1'b1;
                 state_nxt = last_blk ? S_DONE : S_READ;
               end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Address walk, return accumulation and result/handshake registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rc_r       <= '0;
      rc_c       <= '0;
      bx         <= '0;
      idx        <= '0;
      cnt        <= '0;
      blk_base   <= '0;
      line_base  <= '0;
      rd_addr    <= '0;
      drain_cnt  <= '0;
      vld_pipe   <= '0;
      out_pix    <= 1'b0;
      out_idx    <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      vld_pipe   <= RD_LAT'({vld_pipe, state == S_READ});
      cnt        <= cnt_nxt;
      frame_done <= 1'b0;

      if (start_go) begin
        busy      <= 1'b1;
        bx        <= '0;
        idx       <= '0;
        rc_r      <= '0;
        rc_c      <= '0;
        cnt       <= '0;
        drain_cnt <= '0;
        blk_base  <= ADDR_W'(BASE0);
        line_base <= ADDR_W'(BASE0);
        rd_addr   <= ADDR_W'(BASE0);
      end

      if (state == S_READ && !read_last) begin
        if (rc_c == RC_W'(BLK - 1)) begin
          rc_c      <= '0;
          rc_r      <= rc_r + RC_W'(1);
          line_base <= line_base + ADDR_W'(IMG_W);
          rd_addr   <= line_base + ADDR_W'(IMG_W);
        end else begin
          rc_c    <= rc_c + RC_W'(1);
          rd_addr <= rd_addr + ADDR_W'(1);
        end
      end

      if (state == S_DRAIN) drain_cnt <= drain_cnt + DR_W'(1);

      if (drain_end) begin
        drain_cnt <= '0;
        out_valid <= 1'b1;
        out_pix   <= (cnt_nxt >= CNT_W'(THRESH));
        out_idx   <= idx;
      end

      // rd_addr is left on the final address once the frame completes.
      if (accept) begin
        out_valid <= 1'b0;
        cnt       <= '0;
        rc_r      <= '0;
        rc_c      <= '0;
        if (last_blk) begin
          busy       <= 1'b0;
          frame_done <= 1'b1;
        end else begin
          idx       <= idx + IDX_W'(1);
          bx        <= (bx == BX_W'(GRID - 1)) ? '0 : bx + BX_W'(1);
          blk_base  <= next_base;
          line_base <= next_base;
          rd_addr   <= next_base;
        end
      end
    end
  end

  assign bus.rd_addr    = rd_addr;
  assign bus.out_pix    = out_pix;
  assign bus.out_idx    = out_idx;
  assign bus.out_valid  = out_valid;
  assign bus.busy       = busy;
  assign bus.frame_done = frame_done;

endmodule

// File: tb/tb_frame_pool_28.sv
// Bench for frame_pool_28: two instances (read latency 1 and 2) share one framebuffer image
// and are compared against a block-count model of the pooling rule.
module tb_frame_pool_28;

  localparam int IMG_W = 320, X0 = 48, Y0 = 8, BLK = 8, GRID = 28, THRESH = 16;
  localparam int NPIX = GRID * GRID;
  localparam int FB_SIZE = 76800;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start;
  bit   rdy [2];
  bit   rnd_rdy;
  bit   mon_clr;

  frame_pool_28_if bus0 ();
  frame_pool_28_if bus1 ();

  frame_pool_28 #(.RD_LAT(1)) u_lat1 (.clk(clk), .rst(rst), .bus(bus0));
  frame_pool_28 #(.RD_LAT(2)) u_lat2 (.clk(clk), .rst(rst), .bus(bus1));

  bit fb [FB_SIZE];
  logic [11:0] rd0_q, rd1_q, rd1_qq;

  assign bus0.start     = start;
  assign bus1.start     = start;
  assign bus0.out_ready = rdy[0];
  assign bus1.out_ready = rdy[1];
  assign bus0.rd_data   = rd0_q;
  assign bus1.rd_data   = rd1_qq;

  // Framebuffer read ports with garbage in the unused upper bits.
  always @(posedge clk) begin
    rd0_q  <= {11'($urandom), fb[bus0.rd_addr]};
    rd1_q  <= {11'($urandom), fb[bus1.rd_addr]};
    rd1_qq <= rd1_q;
  end

  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) rdy[k] = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  logic [16:0] addr_s [2];
  logic [9:0]  idx_s  [2];
  logic        valid_s[2], pix_s[2], busy_s[2], done_s[2];
  assign addr_s[0] = bus0.rd_addr;   assign addr_s[1] = bus1.rd_addr;
  assign idx_s[0]  = bus0.out_idx;   assign idx_s[1]  = bus1.out_idx;
  assign valid_s[0] = bus0.out_valid; assign valid_s[1] = bus1.out_valid;
  assign pix_s[0]  = bus0.out_pix;   assign pix_s[1]  = bus1.out_pix;
  assign busy_s[0] = bus0.busy;      assign busy_s[1] = bus1.busy;
  assign done_s[0] = bus0.frame_done; assign done_s[1] = bus1.frame_done;

  int got_idx [2][NPIX];
  bit got_pix [2][NPIX];
  int got_n[2], done_n[2], hold_viol[2], hold_seen[2];
  int tr_n[2], tr_first[2], tr_second[2], tr_last[2], tr_max[2];
  bit hold[2], hold_pix[2];
  int hold_idx[2];

  // Capture accepted outputs, hold stability, done pulses and the address trace.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mon_clr) begin
        got_n[k] = 0; done_n[k] = 0; hold_viol[k] = 0; hold_seen[k] = 0;
        tr_n[k] = 0; tr_first[k] = -1; tr_second[k] = -1; tr_last[k] = -1; tr_max[k] = 0;
        hold[k] = 1'b0;
      end else if (rst) begin
        hold[k] = 1'b0;
      end else begin
        if (hold[k] && !(valid_s[k] === 1'b1 && int'(idx_s[k]) == hold_idx[k] &&
                         pix_s[k] === hold_pix[k]))
          hold_viol[k]++;
        if (valid_s[k] && rdy[k]) begin
          if (got_n[k] < NPIX) begin
            got_idx[k][got_n[k]] = int'(idx_s[k]);
            got_pix[k][got_n[k]] = pix_s[k];
          end
          got_n[k]++;
        end
        hold[k]     = valid_s[k] && !rdy[k];
        hold_idx[k] = int'(idx_s[k]);
        hold_pix[k] = pix_s[k];
        if (hold[k]) hold_seen[k]++;
        if (done_s[k]) done_n[k]++;
        if (busy_s[k]) begin
          if (tr_n[k] == 0) tr_first[k] = int'(addr_s[k]);
          if (tr_n[k] == 1) tr_second[k] = int'(addr_s[k]);
          tr_last[k] = int'(addr_s[k]);
          if (int'(addr_s[k]) > tr_max[k]) tr_max[k] = int'(addr_s[k]);
          tr_n[k]++;
        end
      end
    end
  end

  int  checks, errors;
  bit  exp_pix [NPIX];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int pix_addr(input int by, input int bx, input int r, input int c);
    return (Y0 + by * BLK + r) * IMG_W + X0 + bx * BLK + c;
  endfunction

  task automatic set_block(input int by, input int bx, input int n);
    for (int p = 0; p < BLK * BLK; p++) fb[pix_addr(by, bx, p / BLK, p % BLK)] = (p < n);
  endtask

  task automatic build_model();
    for (int i = 0; i < NPIX; i++) begin
      int n = 0;
      for (int r = 0; r < BLK; r++)
        for (int c = 0; c < BLK; c++) n += int'(fb[pix_addr(i / GRID, i % GRID, r, c)]);
      exp_pix[i] = (n >= THRESH);
    end
  endtask

  task automatic clear_mon();
    #1 mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_got(input int k, input int n, input int budget, input string tag);
    int cyc = 0;
    while (got_n[k] < n && cyc < budget) begin @(negedge clk); cyc++; end
    check(tag, 32'(got_n[k] >= n), 32'd1);
  endtask

  task automatic compare_outputs(input int k, input int upto, input string tag);
    int n = (got_n[k] < upto) ? got_n[k] : upto;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_idx%0d_lat%0d", tag, i, k + 1), 32'(got_idx[k][i]), 32'(i));
      check($sformatf("%s_pix%0d_lat%0d", tag, i, k + 1), 32'(got_pix[k][i]), 32'(exp_pix[i]));
    end
  endtask

  initial begin
    int cyc;
    checks = 0; errors = 0;
    rst = 1'b1; start = 1'b0; rnd_rdy = 1'b0; mon_clr = 1'b0;

    // Image A: ~25% density, plus threshold corner cases.
    for (int a = 0; a < FB_SIZE; a++) fb[a] = ($urandom_range(0, 3) == 0);
    set_block(0, 0, 64);
    set_block(0, 1, 0);
    set_block(27, 26, THRESH - 1);
    set_block(27, 27, THRESH);
    build_model();

    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_addr_lat%0d", k + 1),  32'(addr_s[k]),  32'd0);
      check($sformatf("rst_valid_lat%0d", k + 1), 32'(valid_s[k]), 32'd0);
      check($sformatf("rst_pix_lat%0d", k + 1),   32'(pix_s[k]),   32'd0);
      check($sformatf("rst_idx_lat%0d", k + 1),   32'(idx_s[k]),   32'd0);
      check($sformatf("rst_busy_lat%0d", k + 1),  32'(busy_s[k]),  32'd0);
      check($sformatf("rst_done_lat%0d", k + 1),  32'(done_s[k]),  32'd0);
    end
    @(negedge clk) rst = 1'b0;

    // Abort a frame with reset while block 300 is being read.
    clear_mon();
    pulse_start();
    wait_got(0, 300, 25000, "reach_blk300");
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("abort_valid_lat%0d", k + 1), 32'(valid_s[k]), 32'd0);
      check($sformatf("abort_busy_lat%0d", k + 1),  32'(busy_s[k]),  32'd0);
      check($sformatf("abort_addr_lat%0d", k + 1),  32'(addr_s[k]),  32'd0);
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("abort_no_done_lat%0d", k + 1), 32'(done_n[k]), 32'd0);
      compare_outputs(k, 300, "pre_abort");
    end
    @(negedge clk) rst = 1'b0;

    // Full frame with random backpressure and stray start pulses.
    clear_mon();
    rnd_rdy = 1'b1;
    pulse_start();
    repeat (100) @(negedge clk);
    pulse_start();
    wait_got(1, 400, 40000, "reach_blk400");
    pulse_start();
    cyc = 0;
    while (!(done_n[0] > 0 && done_n[1] > 0) && cyc < 40000) begin @(negedge clk); cyc++; end
    check("frame_done_seen", 32'(done_n[0] > 0 && done_n[1] > 0), 32'd1);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("done_pulses_lat%0d", k + 1), 32'(done_n[k]), 32'd1);
      check($sformatf("out_count_lat%0d", k + 1),   32'(got_n[k]),  32'(NPIX));
      compare_outputs(k, NPIX, "frame");
      check($sformatf("blk0_full_lat%0d", k + 1),   32'(got_pix[k][0]),   32'd1);
      check($sformatf("blk1_empty_lat%0d", k + 1),  32'(got_pix[k][1]),   32'd0);
      check($sformatf("idx782_15px_lat%0d", k + 1), 32'(got_pix[k][782]), 32'd0);
      check($sformatf("idx783_16px_lat%0d", k + 1), 32'(got_pix[k][783]), 32'd1);
      check($sformatf("addr_first_lat%0d", k + 1),  32'(tr_first[k]),  32'd2608);
      check($sformatf("addr_second_lat%0d", k + 1), 32'(tr_second[k]), 32'd2609);
      check($sformatf("addr_last_lat%0d", k + 1),   32'(tr_last[k]),   32'd74191);
      check($sformatf("addr_in_range_lat%0d", k + 1), 32'(tr_max[k] < FB_SIZE), 32'd1);
      check($sformatf("hold_stable_lat%0d", k + 1), 32'(hold_viol[k]), 32'd0);
      check($sformatf("hold_exercised_lat%0d", k + 1), 32'(hold_seen[k] > 0), 32'd1);
      check($sformatf("idle_busy_lat%0d", k + 1),   32'(busy_s[k]),    32'd0);
    end

    // Image B: a fresh start from IDLE runs a new frame from index 0.
    for (int a = 0; a < FB_SIZE; a++) fb[a] = 1'b1;
    set_block(0, 1, 0);
    set_block(0, 2, THRESH - 1);
    set_block(0, 3, THRESH);
    build_model();
    clear_mon();
    rnd_rdy = 1'b0;
    pulse_start();
    wait_got(1, 30, 4000, "second_frame_progress");
    for (int k = 0; k < 2; k++) begin
      check($sformatf("second_busy_lat%0d", k + 1),  32'(busy_s[k]),  32'd1);
      check($sformatf("second_first_lat%0d", k + 1), 32'(tr_first[k]), 32'd2608);
      check($sformatf("second_pix0_lat%0d", k + 1),  32'(got_pix[k][0]), 32'd1);
      check($sformatf("second_pix2_lat%0d", k + 1),  32'(got_pix[k][2]), 32'd0);
      compare_outputs(k, 30, "second");
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
